// File: rtl/alu_share_arb.sv
// ---------------------------------------------------------------------------
// alu_share_arb
//
// Two requesters share a single combinational 32-bit ALU. Each cycle at most
// one requester is granted; its operands go through the ALU and the result is
// captured in that requester's one-entry result slot at the same clock edge.
// Contention between two eligible requesters is settled by a round-robin
// priority pointer that always points at the port that lost the last grant.
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer holds valid and its payload stable until the transfer.
//   ready may depend combinationally on valid.
//
// Ports (i in {0,1}):
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req<i>_valid/ready request handshake
//   req<i>_a/_b/_op    operands and 4-bit opcode
//   resp<i>_valid/ready response handshake (valid == slot occupied)
//   resp<i>_result     registered ALU result
//   resp<i>_overflow   registered signed overflow flag
//   acc_cnt<i>         saturating count of accepted requests
// ---------------------------------------------------------------------------
module alu_share_arb #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_result,
    output logic        resp0_overflow,
    output logic [15:0] acc_cnt0,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_result,
    output logic        resp1_overflow,
    output logic [15:0] acc_cnt1
);

    localparam logic       RESET_PTR = (RESET_PRIO != 0);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_PASS = 4'b1001;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        ptr_q, ptr_d;              // port that wins the next tie
    logic        slot0_valid_q, slot0_valid_d;
    logic        slot1_valid_q, slot1_valid_d;
    logic [31:0] result0_q, result0_d;
    logic [31:0] result1_q, result1_d;
    logic        ovf0_q, ovf0_d;
    logic        ovf1_q, ovf1_d;
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic drain0, drain1;
    logic elig0, elig1;
    logic grant0, grant1;

    assign drain0 = slot0_valid_q && resp0_ready;
    assign drain1 = slot1_valid_q && resp1_ready;

    // A port may issue when its slot is free, or is being emptied this cycle.
    assign elig0 = req0_valid && (!slot0_valid_q || resp0_ready);
    assign elig1 = req1_valid && (!slot1_valid_q || resp1_ready);

    // rst gating keeps ready low for the whole asynchronous reset window,
    // not just from the next edge onward.
    assign grant0 = !rst && elig0 && (!elig1 || (ptr_q == 1'b0));
    assign grant1 = !rst && elig1 && (!elig0 || (ptr_q == 1'b1));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // ------------------------------------------------------------------
    // Shared ALU, fed by whichever port is granted
    // ------------------------------------------------------------------
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_sum, alu_diff, alu_res;
    logic [4:0]  alu_shamt;
    logic        alu_ovf;

    always_comb begin
        alu_a  = grant1 ? req1_a  : req0_a;
        alu_b  = grant1 ? req1_b  : req0_b;
        alu_op = grant1 ? req1_op : req0_op;
    end

    assign alu_sum   = alu_a + alu_b;
    assign alu_diff  = alu_a - alu_b;
    assign alu_shamt = alu_b[4:0];

    always_comb begin
        alu_res = alu_sum;
        case (alu_op)
            OP_ADD:  alu_res = alu_sum;
            OP_SUB:  alu_res = alu_diff;
            OP_SLL:  alu_res = alu_a << alu_shamt;
            OP_SLT:  alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: alu_res = {31'd0, (alu_a < alu_b)};
            OP_XOR:  alu_res = alu_a ^ alu_b;
            OP_SRL:  alu_res = alu_a >> alu_shamt;
            OP_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_shamt);
            OP_OR:   alu_res = alu_a | alu_b;
            OP_AND:  alu_res = alu_a & alu_b;
            OP_PASS: alu_res = alu_b;
            default: alu_res = alu_sum;
        endcase
    end

    // Overflow reports the subtractor for SUB and the adder for everything
    // else, independent of which result is selected.
    always_comb begin
        if (alu_op == OP_SUB) begin
            alu_ovf = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
        end else begin
            alu_ovf = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d         = ptr_q;
        slot0_valid_d = slot0_valid_q;
        slot1_valid_d = slot1_valid_q;
        result0_d     = result0_q;
        result1_d     = result1_q;
        ovf0_d        = ovf0_q;
        ovf1_d        = ovf1_q;
        cnt0_d        = cnt0_q;
        cnt1_d        = cnt1_q;

        // Pointer moves to the loser only when someone was granted.
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end

        // A load wins over a drain so a same-cycle drain+reload stays valid.
        if (grant0) begin
            slot0_valid_d = 1'b1;
            result0_d     = alu_res;
            ovf0_d        = alu_ovf;
            if (cnt0_q != 16'hFFFF) begin
                cnt0_d = cnt0_q + 16'd1;
            end
        end else if (drain0) begin
            slot0_valid_d = 1'b0;
        end

        if (grant1) begin
            slot1_valid_d = 1'b1;
            result1_d     = alu_res;
            ovf1_d        = alu_ovf;
            if (cnt1_q != 16'hFFFF) begin
                cnt1_d = cnt1_q + 16'd1;
            end
        end else if (drain1) begin
            slot1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= RESET_PTR;
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
            result0_q     <= 32'd0;
            result1_q     <= 32'd0;
            ovf0_q        <= 1'b0;
            ovf1_q        <= 1'b0;
            cnt0_q        <= 16'd0;
            cnt1_q        <= 16'd0;
        end else begin
            ptr_q         <= ptr_d;
            slot0_valid_q <= slot0_valid_d;
            slot1_valid_q <= slot1_valid_d;
            result0_q     <= result0_d;
            result1_q     <= result1_d;
            ovf0_q        <= ovf0_d;
            ovf1_q        <= ovf1_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign resp0_valid    = slot0_valid_q;
    assign resp1_valid    = slot1_valid_q;
    assign resp0_result   = result0_q;
    assign resp1_result   = result1_q;
    assign resp0_overflow = ovf0_q;
    assign resp1_overflow = ovf1_q;
    assign acc_cnt0       = cnt0_q;
    assign acc_cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arb
//
// Bench for alu_share_arb. Inputs change on the falling edge; outputs are
// sampled 1 time unit after that falling edge. A reference model holds one
// expected-result queue per port ({overflow, result}), the round-robin turn
// and the accepted-request counts.
// ---------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam int RESET_PRIO = 0;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_overflow;
    logic [31:0] req0_a, req0_b, resp0_result;
    logic [3:0]  req0_op;
    logic [15:0] acc_cnt0;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_overflow;
    logic [31:0] req1_a, req1_b, resp1_result;
    logic [3:0]  req1_op;
    logic [15:0] acc_cnt1;

    alu_share_arb #(.RESET_PRIO(RESET_PRIO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_op        (req0_op),
        .resp0_valid    (resp0_valid),
        .resp0_ready    (resp0_ready),
        .resp0_result   (resp0_result),
        .resp0_overflow (resp0_overflow),
        .acc_cnt0       (acc_cnt0),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_op        (req1_op),
        .resp1_valid    (resp1_valid),
        .resp1_ready    (resp1_ready),
        .resp1_result   (resp1_result),
        .resp1_overflow (resp1_overflow),
        .acc_cnt1       (acc_cnt1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int          m_turn;     // port that wins when both want the ALU
    int          m_cnt0;
    int          m_cnt1;

    // Plain-arithmetic ALU reference: overflow is judged by whether the
    // exact signed result fits in 32 bits.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        longint sa, sb, exact, shifted;
        int     sh;
        logic [31:0] r;
        logic        ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        exact = (op == 4'b1000) ? (sa - sb) : (sa + sb);
        ov = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        case (op)
            4'b1000: r = a - b;
            4'b0001: r = a << sh;
            4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: begin
                shifted = sa >>> sh;
                r = shifted[31:0];
            end
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            4'b1001: r = b;
            default: r = a + b;
        endcase
        return {ov, r};
    endfunction

    function automatic logic exp_grant(input int p);
        logic want0, want1;
        if (rst) return 1'b0;
        want0 = req0_valid && (exp_q0.size() == 0 || resp0_ready);
        want1 = req1_valid && (exp_q1.size() == 0 || resp1_ready);
        if (p == 0) return want0 && (!want1 || m_turn == 0);
        return want1 && (!want0 || m_turn == 1);
    endfunction

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        m_turn = RESET_PRIO;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // ---------------- drivers ----------------
    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic rr);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op; resp0_ready = rr;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic rr);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op; resp1_ready = rr;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        logic g0, g1, d0, d1;
        g0 = exp_grant(0);
        g1 = exp_grant(1);
        d0 = (exp_q0.size() != 0) && resp0_ready;
        d1 = (exp_q1.size() != 0) && resp1_ready;
        @(posedge clk);
        if (d0) void'(exp_q0.pop_front());
        if (d1) void'(exp_q1.pop_front());
        if (g0) begin
            exp_q0.push_back(alu_ref(req0_a, req0_b, req0_op));
            if (m_cnt0 < 65535) m_cnt0++;
            m_turn = 1;
        end
        if (g1) begin
            exp_q1.push_back(alu_ref(req1_a, req1_b, req1_op));
            if (m_cnt1 < 65535) m_cnt1++;
            m_turn = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b1, 32'd1, 32'd2, 4'd0, 1'b1);
        drive1(1'b1, 32'd3, 32'd4, 4'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({resp0_valid, resp1_valid, resp0_overflow, resp1_overflow} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {resp0_valid, resp1_valid, resp0_overflow, resp1_overflow});
        end
        n_checks++;
        if (resp0_result !== 32'd0 || resp1_result !== 32'd0 || acc_cnt0 !== 16'd0 || acc_cnt1 !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_values: got res %h %h cnt %h %h expected all 0",
                     resp0_result, resp1_result, acc_cnt0, acc_cnt1);
        end
        do_reset();
    endtask

    task automatic test_single_op();
        drive0(1'b1, 32'd5, 32'd7, 4'b0000, 1'b1);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        tick();
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        #1;
        n_checks++;
        if ({resp0_valid, resp0_overflow, resp0_result} !== {1'b1, 1'b0, 32'd12}) begin
            n_errors++;
            $display("FAIL single_result: got v=%b ovf=%b res=%0d expected v=1 ovf=0 res=12",
                     resp0_valid, resp0_overflow, resp0_result);
        end
        n_checks++;
        if (acc_cnt0 !== 16'd1) begin
            n_errors++;
            $display("FAIL single_count: got %0d expected 1", acc_cnt0);
        end
        tick();
    endtask

    task automatic test_opcodes();
        logic [31:0] ta [5] = '{32'hF0000000, 32'd1, 32'd0, 32'd2, 32'h80000000};
        logic [31:0] tb [5] = '{32'd4, 32'hFFFFFFFF, 32'h0000ABCD, 32'd3, 32'h80000000};
        logic [3:0]  top[5] = '{4'b1101, 4'b0011, 4'b1001, 4'b1111, 4'b0000};
        logic [32:0] tex[5] = '{{1'b0, 32'hFF000000}, {1'b0, 32'd1}, {1'b0, 32'h0000ABCD},
                                {1'b0, 32'd5}, {1'b1, 32'd0}};
        for (int k = 0; k < 5; k++) begin
            drive0(1'b1, ta[k], tb[k], top[k], 1'b1);
            tick();
            drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
            #1;
            n_checks++;
            if ({resp0_overflow, resp0_result} !== tex[k] || resp0_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL opcode_%0d: got v=%b ovf/res=%h expected v=1 ovf/res=%h",
                         k, resp0_valid, {resp0_overflow, resp0_result}, tex[k]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        drive1(1'b1, 32'h80000000, 32'd1, 4'b1000, 1'b0);
        tick();
        drive1(1'b1, 32'd10, 32'd20, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({req1_ready, resp1_valid, resp1_overflow, resp1_result} !== {1'b0, 1'b1, 1'b1, 32'h7FFFFFFF}) begin
                n_errors++;
                $display("FAIL backpressure_hold_%0d: got rdy=%b v=%b ovf=%b res=%h expected 0 1 1 7fffffff",
                         k, req1_ready, resp1_valid, resp1_overflow, resp1_result);
            end
            tick();
        end
        resp1_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure_release: got rdy=%b expected 1", req1_ready);
        end
        tick();
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        #1;
        n_checks++;
        if ({resp1_valid, resp1_overflow, resp1_result} !== {1'b1, 1'b0, 32'd30}) begin
            n_errors++;
            $display("FAIL backpressure_reload: got v=%b ovf=%b res=%0d expected 1 0 30",
                     resp1_valid, resp1_overflow, resp1_result);
        end
        resp1_ready = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        int diff;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive0(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            drive1(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL contention_grant_%0d: got %b expected %b", k,
                         {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
        end
        diff = int'(acc_cnt0) - int'(acc_cnt1);
        n_checks++;
        if (diff > 1 || diff < -1 || int'(acc_cnt0) != m_cnt0 || int'(acc_cnt1) != m_cnt1) begin
            n_errors++;
            $display("FAIL contention_counts: got %0d %0d expected %0d %0d", acc_cnt0, acc_cnt1, m_cnt0, m_cnt1);
        end
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            drive0($urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            drive1($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (req0_ready !== exp_grant(0) || req1_ready !== exp_grant(1)) begin
                n_errors++;
                $display("FAIL random_grant_%0d: got %b%b expected %b%b", k,
                         req0_ready, req1_ready, exp_grant(0), exp_grant(1));
            end
            n_checks++;
            if (resp0_valid !== (exp_q0.size() != 0) ||
                (exp_q0.size() != 0 && {resp0_overflow, resp0_result} !== exp_q0[0])) begin
                n_errors++;
                $display("FAIL random_resp0_%0d: got v=%b %h expected v=%b %h", k, resp0_valid,
                         {resp0_overflow, resp0_result}, exp_q0.size() != 0,
                         (exp_q0.size() != 0) ? exp_q0[0] : 33'd0);
            end
            n_checks++;
            if (resp1_valid !== (exp_q1.size() != 0) ||
                (exp_q1.size() != 0 && {resp1_overflow, resp1_result} !== exp_q1[0])) begin
                n_errors++;
                $display("FAIL random_resp1_%0d: got v=%b %h expected v=%b %h", k, resp1_valid,
                         {resp1_overflow, resp1_result}, exp_q1.size() != 0,
                         (exp_q1.size() != 0) ? exp_q1[0] : 33'd0);
            end
            n_checks++;
            if (int'(acc_cnt0) != m_cnt0 || int'(acc_cnt1) != m_cnt1) begin
                n_errors++;
                $display("FAIL random_count_%0d: got %0d %0d expected %0d %0d", k,
                         acc_cnt0, acc_cnt1, m_cnt0, m_cnt1);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive0(1'b1, 32'd1, 32'd1, 4'd0, 1'b0);
        drive1(1'b1, 32'd2, 32'd2, 4'd0, 1'b0);
        tick();
        tick();
        #1;
        n_checks++;
        if ({resp0_valid, resp1_valid} !== 2'b11) begin
            n_errors++;
            $display("FAIL async_fill: got %b expected 11", {resp0_valid, resp1_valid});
        end
        // Pulse reset entirely between clock edges.
        rst = 1'b1;
        #1;
        n_checks++;
        if ({resp0_valid, resp1_valid, req0_ready, req1_ready} !== 4'b0000 ||
            acc_cnt0 !== 16'd0 || acc_cnt1 !== 16'd0) begin
            n_errors++;
            $display("FAIL async_clear: got v=%b rdy=%b cnt=%0d %0d expected 00 00 0 0",
                     {resp0_valid, resp1_valid}, {req0_ready, req1_ready}, acc_cnt0, acc_cnt1);
        end
        #1;
        rst = 1'b0;
        model_reset();
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== ((RESET_PRIO == 0) ? 2'b10 : 2'b01)) begin
            n_errors++;
            $display("FAIL async_first_grant: got %b expected %b", {req0_ready, req1_ready},
                     (RESET_PRIO == 0) ? 2'b10 : 2'b01);
        end
        tick();
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        drive0(1'b1, 32'd3, 32'd4, 4'd0, 1'b1);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        for (int k = 1; k <= 65540; k++) begin
            tick();
            if (k == 65534) begin
                #1;
                n_checks++;
                if (acc_cnt0 !== 16'hFFFE) begin
                    n_errors++;
                    $display("FAIL sat_below: got %h expected fffe", acc_cnt0);
                end
            end
        end
        #1;
        n_checks++;
        if (acc_cnt0 !== 16'hFFFF || int'(acc_cnt0) != m_cnt0 || acc_cnt1 !== 16'd0) begin
            n_errors++;
            $display("FAIL sat_final: got %h %h expected ffff 0000", acc_cnt0, acc_cnt1);
        end
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        tick();
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_op();
        test_opcodes();
        test_backpressure();
        test_contention();
        test_random();
        test_async_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
